aes_block_packer: RTL

Upstream stage of the AES encrypt datapath. It accepts a 32-bit word stream with valid/ready handshakes and a last-word flag, and packs it into 128-bit plaintext blocks. Each message is closed with PKCS#7 padding. The blocks it produces drive the `in[127:0]` input of the combinational AES-128 encrypt core, and it provides the registered, flow-controlled boundary that the core itself lacks.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_block_packer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath widths, padding constant and packer state type
package aes_pkg;
  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_WORD_W      = 32;

  localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } packer_state_e;
endpackage

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs a 32-bit word stream into PKCS#7-padded 128-bit AES plaintext blocks
module aes_block_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_WORD_W-1:0]  in_data,
  input  logic                   in_last,
  input  logic [2:0]             in_bytes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   out_last,
  output logic [15:0]            msg_blocks
);

  packer_state_e          state;
  logic [AES_BLOCK_W-1:0] acc;
  logic [4:0]             cnt;
  logic                   pend_pad;

  logic [2:0]             eff_bytes;
  logic [4:0]             new_cnt;
  logic [AES_BLOCK_W-1:0] new_acc;
  logic                   in_fire;
  logic                   out_fire;

  // Writes nb bytes of data at byte offset pos; on a last word also fills
  // every byte past the data with the pad value (16-n) or zero.
  function automatic logic [AES_BLOCK_W-1:0] lane_fill(
    input logic [AES_BLOCK_W-1:0] cur,
    input logic [4:0]             pos,
    input logic [AES_WORD_W-1:0]  data,
    input logic [2:0]             nb,
    input logic                   last,
    input logic                   pad_en
  );
    logic [AES_BLOCK_W-1:0] r;
    logic [4:0]             n;
    logic [7:0]             pv;
    r  = cur;
    n  = pos + {2'b00, nb};
    pv = pad_en ? 8'(5'd16 - n) : 8'h00;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (i >= int'(pos) && i < int'(n))
        r[AES_BLOCK_W-1-8*i -: 8] = data[AES_WORD_W-1-8*(i-int'(pos)) -: 8];
      else if (last && i >= int'(n))
        r[AES_BLOCK_W-1-8*i -: 8] = pv;
    end
    return r;
  endfunction

  assign in_ready  = rst_n && (state == FILL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Out-of-range byte counts on a last word collapse to a full word.
  assign eff_bytes = (in_last && in_bytes >= 3'd1 && in_bytes <= 3'd4) ? in_bytes : 3'd4;
  assign new_cnt   = cnt + {2'b00, eff_bytes};
  assign new_acc   = lane_fill(acc, cnt, in_data, eff_bytes, in_last, PAD_EN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      acc        <= '0;
      cnt        <= '0;
      pend_pad   <= 1'b0;
      out_valid  <= 1'b0;
      out_block  <= '0;
      out_last   <= 1'b0;
      msg_blocks <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_fire) begin
            acc <= new_acc;
            if (in_last || new_cnt == 5'd16) begin
              state     <= EMIT;
              out_valid <= 1'b1;
              out_block <= new_acc;
              out_last  <= in_last && (new_cnt != 5'd16 || !PAD_EN);
              pend_pad  <= in_last && new_cnt == 5'd16 && PAD_EN;
              cnt       <= '0;
            end else begin
              cnt <= new_cnt;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            msg_blocks <= out_last ? 16'd0 : msg_blocks + 16'd1;
            acc        <= '0;
            cnt        <= '0;
            if (pend_pad) begin
              // A full-length message still owes one block of pure padding.
              state     <= PAD;
              out_block <= {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
              out_last  <= 1'b1;
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
            end
          end
        end
        PAD: begin
          if (out_fire) begin
            state      <= FILL;
            pend_pad   <= 1'b0;
            msg_blocks <= '0;
            out_valid  <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
